// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix multiply sequencer.
// Optional build macro used by the top level: MATRIX_SEQ_TIMEOUT_EN.
package matrix_pkg;

  localparam logic [2:0] MUL_OP  = 3'b101;
  localparam logic [2:0] IDLE_OP = 3'b000;
  localparam int         TIMEOUT = 64;

  typedef logic signed [31:0] elem_t;
  typedef logic [3:0]         idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CLEAR,
    S_FINISH,
    S_ABORT
  } state_t;

endpackage

// File: rtl/matrix_store_4x4.sv
// 4x4 element register file: synchronous write, combinational element read
// plus one full row and one full column read in parallel.
module matrix_store_4x4
  import matrix_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_en,
  input  idx_t       i_wr_addr,
  input  elem_t      i_wr_data,
  input  idx_t       i_rd_addr,
  output elem_t      o_rd_data,
  input  logic [1:0] i_row,
  input  logic [1:0] i_col,
  output elem_t      o_row_lane [4],
  output elem_t      o_col_lane [4]
);

  elem_t r_mem [16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) r_mem[k] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign o_row_lane[gi] = r_mem[{i_row, 2'(gi)}];
      assign o_col_lane[gi] = r_mem[{2'(gi), i_col}];
    end
  endgenerate

endmodule

// File: rtl/matrix_mult_sequencer.sv
// Walks all 16 (row,col) pairs of A*B through an external dot-product unit and
// collects the results in C. Define MATRIX_SEQ_TIMEOUT_EN to bound the Done wait.
module matrix_mult_sequencer
  import matrix_pkg::*;
(
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        LoadEn,
  input  logic        LoadSel,
  input  logic [3:0]  LoadAddr,
  input  logic [31:0] LoadData,
  input  logic        Start,
  input  logic [3:0]  ReadAddr,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Finished,
  output logic        AbortErr,
  output logic [2:0]  Operation,
  output logic        ClearAll,
  output logic [31:0] ColumnA1,
  output logic [31:0] ColumnA2,
  output logic [31:0] ColumnA3,
  output logic [31:0] ColumnA4,
  output logic [31:0] RowB1,
  output logic [31:0] RowB2,
  output logic [31:0] RowB3,
  output logic [31:0] RowB4,
  input  logic        Error,
  input  logic        Done,
  input  logic [31:0] Result
);

  state_t r_state, w_state_next;
  idx_t   r_idx, w_fetch_idx;
  logic   r_busy, r_finished, r_abort_err;
  logic   w_wr_a, w_wr_b, w_c_wr, w_fetch, w_wait_timeout;
  elem_t  r_op_a [4];
  elem_t  r_op_b [4];
  elem_t  w_a_lane [4];
  elem_t  w_b_lane [4];
  elem_t  w_a_fwd [4];
  elem_t  w_b_fwd [4];

  assign w_wr_a  = LoadEn & ~r_busy & ~LoadSel;
  assign w_wr_b  = LoadEn & ~r_busy & LoadSel;
  assign w_c_wr  = (r_state == S_WAIT) & Done & ~Error;
  assign w_fetch = (w_state_next == S_ISSUE) && (r_state != S_ISSUE);
  assign w_fetch_idx = (r_state == S_CLEAR) ? r_idx + 4'd1 : 4'd0;

  matrix_store_4x4 u_store_a (
    .clk(Clock), .rst_n(ResetN), .i_wr_en(w_wr_a), .i_wr_addr(LoadAddr),
    .i_wr_data(LoadData), .i_rd_addr(4'd0), .o_rd_data(),
    .i_row(w_fetch_idx[3:2]), .i_col(2'd0), .o_row_lane(w_a_lane), .o_col_lane()
  );

  matrix_store_4x4 u_store_b (
    .clk(Clock), .rst_n(ResetN), .i_wr_en(w_wr_b), .i_wr_addr(LoadAddr),
    .i_wr_data(LoadData), .i_rd_addr(4'd0), .o_rd_data(),
    .i_row(2'd0), .i_col(w_fetch_idx[1:0]), .o_row_lane(), .o_col_lane(w_b_lane)
  );

  matrix_store_4x4 u_store_c (
    .clk(Clock), .rst_n(ResetN), .i_wr_en(w_c_wr), .i_wr_addr(r_idx),
    .i_wr_data(Result), .i_rd_addr(ReadAddr), .o_rd_data(ReadData),
    .i_row(2'd0), .i_col(2'd0), .o_row_lane(), .o_col_lane()
  );

  // A write landing on the same edge as Start must be seen by the first fetch.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
      assign w_a_fwd[gi] = (w_wr_a && LoadAddr == {w_fetch_idx[3:2], 2'(gi)}) ? LoadData : w_a_lane[gi];
      assign w_b_fwd[gi] = (w_wr_b && LoadAddr == {2'(gi), w_fetch_idx[1:0]}) ? LoadData : w_b_lane[gi];
    end
  endgenerate

`ifdef MATRIX_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wait_cnt;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_wait_timeout = (r_wait_cnt == CW'(TIMEOUT - 1));
`else
  assign w_wait_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    Operation    = IDLE_OP;
    ClearAll     = 1'b0;
    case (r_state)
      S_IDLE:   if (Start) w_state_next = S_ISSUE;
      S_ISSUE: begin
        Operation    = MUL_OP;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        Operation = MUL_OP;
        if (Done)                w_state_next = Error ? S_ABORT : S_CLEAR;
        else if (w_wait_timeout) w_state_next = S_ABORT;
      end
      S_CLEAR: begin
        ClearAll     = 1'b1;
        w_state_next = (r_idx == 4'd15) ? S_FINISH : S_ISSUE;
      end
      S_FINISH: w_state_next = S_IDLE;
      S_ABORT: begin
        ClearAll     = 1'b1;
        w_state_next = S_IDLE;
      end
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_finished  <= 1'b0;
      r_abort_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && Start) begin
        r_idx       <= '0;
        r_busy      <= 1'b1;
        r_finished  <= 1'b0;
        r_abort_err <= 1'b0;
      end
      if (r_state == S_CLEAR && r_idx != 4'd15) r_idx <= r_idx + 4'd1;
      if (w_state_next == S_FINISH) begin
        r_busy     <= 1'b0;
        r_finished <= 1'b1;
      end
      if (w_state_next == S_ABORT) begin
        r_busy      <= 1'b0;
        r_abort_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int k = 0; k < 4; k++) begin
        r_op_a[k] <= '0;
        r_op_b[k] <= '0;
      end
    end else if (w_fetch) begin
      for (int k = 0; k < 4; k++) begin
        r_op_a[k] <= w_a_fwd[k];
        r_op_b[k] <= w_b_fwd[k];
      end
    end
  end

  assign Busy     = r_busy;
  assign Finished = r_finished;
  assign AbortErr = r_abort_err;
  assign ColumnA1 = r_op_a[0];
  assign ColumnA2 = r_op_a[1];
  assign ColumnA3 = r_op_a[2];
  assign ColumnA4 = r_op_a[3];
  assign RowB1    = r_op_b[0];
  assign RowB2    = r_op_b[1];
  assign RowB3    = r_op_b[2];
  assign RowB4    = r_op_b[3];

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Bench for matrix_mult_sequencer: a behavioural dot-product unit feeds a
// scoreboard of expected C elements, checked after each sequence.
module tb_matrix_mult_sequencer;

  localparam logic [2:0] EXP_MUL  = 3'b101;
  localparam logic [2:0] EXP_IDLE = 3'b000;
  localparam int         EXP_TO   = 64;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        LoadEn = 1'b0;
  logic        LoadSel = 1'b0;
  logic [3:0]  LoadAddr = '0;
  logic [31:0] LoadData = '0;
  logic        Start = 1'b0;
  logic [3:0]  ReadAddr = '0;
  logic [31:0] ReadData;
  logic        Busy, Finished, AbortErr, ClearAll;
  logic [2:0]  Operation;
  logic signed [31:0] ColumnA1, ColumnA2, ColumnA3, ColumnA4;
  logic signed [31:0] RowB1, RowB2, RowB3, RowB4;
  logic        Error = 1'b0;
  logic        Done = 1'b0;
  logic signed [31:0] Result = '0;

  matrix_mult_sequencer dut (
    .Clock(Clock), .ResetN(ResetN), .LoadEn(LoadEn), .LoadSel(LoadSel),
    .LoadAddr(LoadAddr), .LoadData(LoadData), .Start(Start), .ReadAddr(ReadAddr),
    .ReadData(ReadData), .Busy(Busy), .Finished(Finished), .AbortErr(AbortErr),
    .Operation(Operation), .ClearAll(ClearAll),
    .ColumnA1(ColumnA1), .ColumnA2(ColumnA2), .ColumnA3(ColumnA3), .ColumnA4(ColumnA4),
    .RowB1(RowB1), .RowB2(RowB2), .RowB3(RowB3), .RowB4(RowB4),
    .Error(Error), .Done(Done), .Result(Result)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int          addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   ma[16];
  int   mb[16];
  int   n_checks = 0;
  int   n_fail = 0;
  int   clr_cnt = 0;
  int   m_delay = 2;
  int   m_err_idx = -1;
  int   m_idx = 0;
  int   m_cnt = 0;
  bit   m_never = 1'b0;

  // Behavioural unit: Done after m_delay cycles of MUL_OP, result from the bus.
  initial begin
    forever begin
      @(negedge Clock);
      if (!ResetN) begin
        Done = 1'b0; Error = 1'b0; m_cnt = 0;
      end else if (Operation == EXP_MUL) begin
        if (!Done) begin
          m_cnt++;
          if (m_cnt >= m_delay && !m_never) begin
            Result = ColumnA1 * RowB1 + ColumnA2 * RowB2 + ColumnA3 * RowB3 + ColumnA4 * RowB4;
            Done   = 1'b1;
            Error  = (m_idx == m_err_idx);
            if (!Error) begin
              exp_t e;
              int   s;
              s = 0;
              for (int k = 0; k < 4; k++) s += ma[(m_idx / 4) * 4 + k] * mb[k * 4 + (m_idx % 4)];
              e.addr = m_idx;
              e.val  = s;
              sb.push_back(e);
            end
          end
        end
      end else begin
        if (Done) m_idx++;
        Done = 1'b0; Error = 1'b0; m_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clock);
      if (ClearAll) clr_cnt++;
    end
  end

  task automatic write_elem(input bit sel, input int addr, input int data);
    @(negedge Clock);
    LoadEn = 1'b1; LoadSel = sel; LoadAddr = addr[3:0]; LoadData = data;
    @(negedge Clock);
    LoadEn = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 16; i++) begin
      write_elem(1'b0, i, ma[i]);
      write_elem(1'b1, i, mb[i]);
    end
  endtask

  task automatic apply_reset();
    @(negedge Clock);
    ResetN = 1'b0;
    @(negedge Clock);
    ResetN = 1'b1;
    m_idx = 0; m_err_idx = -1; m_delay = 2; m_never = 1'b0;
    sb.delete();
    clr_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc, output bit timed_out);
    cyc = 1;
    timed_out = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!Busy) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge Clock);
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (Busy !== 1'b0 || Finished !== 1'b0 || AbortErr !== 1'b0 || ClearAll !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy=%b fin=%b abort=%b clr=%b required all 0", Busy, Finished, AbortErr, ClearAll);
    end
    n_checks++;
    if (Operation !== EXP_IDLE || ColumnA1 !== 0 || RowB4 !== 0) begin
      n_fail++;
      $display("FAIL reset_bus: got op=%b a1=%0d b4=%0d required 000/0/0", Operation, ColumnA1, RowB4);
    end
    ResetN = 1'b1;
    for (int i = 0; i < 16; i += 5) begin
      ReadAddr = i[3:0];
      #1;
      n_checks++;
      if (ReadData !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_c[%0d]: got %0d required 0", i, ReadData);
      end
    end
    $display("reset: checked flags, bus and C");
  endtask

  task automatic test_identity();
    int cyc;
    bit to;
    exp_t e;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      ma[i] = (i / 4 == i % 4) ? 1 : 0;
      mb[i] = i;
    end
    load_all();
    clr_cnt = 0;
    pulse_start();
    n_checks++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ident_busy: got %b required 1", Busy);
    end
    wait_idle(cyc, to);
    n_checks++;
    if (to || cyc < 49) begin
      n_fail++;
      $display("FAIL ident_len: got timeout=%0d cycles=%0d required no timeout, >=49", to, cyc);
    end
    @(negedge Clock);
    n_checks++;
    if (Finished !== 1'b1 || AbortErr !== 1'b0 || clr_cnt != 16) begin
      n_fail++;
      $display("FAIL ident_done: got fin=%b abort=%b clears=%0d required 1/0/16", Finished, AbortErr, clr_cnt);
    end
    n_checks++;
    if (sb.size() != 16) begin
      n_fail++;
      $display("FAIL ident_sb: got %0d results required 16", sb.size());
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ReadAddr = e.addr[3:0];
      #1;
      n_checks++;
      if (ReadData !== e.val || ReadData !== mb[e.addr]) begin
        n_fail++;
        $display("FAIL ident_c[%0d]: got %0d required %0d", e.addr, $signed(ReadData), $signed(e.val));
      end
    end
    $display("identity: run of %0d cycles, %0d clears", cyc, clr_cnt);
  endtask

  task automatic test_signed_and_same_cycle_load();
    int cyc;
    bit to;
    exp_t e;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      ma[i] = 4;
      mb[i] = -5;
    end
    for (int i = 1; i < 16; i++) write_elem(1'b0, i, ma[i]);
    for (int i = 0; i < 16; i++) write_elem(1'b1, i, mb[i]);
    @(negedge Clock);
    LoadEn = 1'b1; LoadSel = 1'b0; LoadAddr = 4'd0; LoadData = 32'd4; Start = 1'b1;
    @(negedge Clock);
    LoadEn = 1'b0; Start = 1'b0;
    wait_idle(cyc, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL signed_timeout: got busy=%b required 0", Busy);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ReadAddr = e.addr[3:0];
      #1;
      n_checks++;
      if (ReadData !== e.val || $signed(ReadData) != -80) begin
        n_fail++;
        $display("FAIL signed_c[%0d]: got %0d required %0d", e.addr, $signed(ReadData), -80);
      end
    end
    $display("signed: A=4, B=-5 with A[0][0] written alongside Start");
  endtask

  task automatic test_error();
    int cyc;
    bit to;
    exp_t e;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      ma[i] = i + 1;
      mb[i] = 3 - i;
    end
    load_all();
    m_err_idx = 5;
    pulse_start();
    wait_idle(cyc, to);
    n_checks++;
    if (to || AbortErr !== 1'b1 || Busy !== 1'b0 || Finished !== 1'b0) begin
      n_fail++;
      $display("FAIL err_flags: got abort=%b busy=%b fin=%b required 1/0/0", AbortErr, Busy, Finished);
    end
    n_checks++;
    if (sb.size() != 5) begin
      n_fail++;
      $display("FAIL err_count: got %0d results required 5", sb.size());
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ReadAddr = e.addr[3:0];
      #1;
      n_checks++;
      if (ReadData !== e.val) begin
        n_fail++;
        $display("FAIL err_c[%0d]: got %0d required %0d", e.addr, $signed(ReadData), $signed(e.val));
      end
    end
    for (int i = 5; i < 16; i++) begin
      ReadAddr = i[3:0];
      #1;
      n_checks++;
      if (ReadData !== 32'd0) begin
        n_fail++;
        $display("FAIL err_untouched[%0d]: got %0d required 0", i, $signed(ReadData));
      end
    end
    m_err_idx = -1;
    m_idx = 0;
    pulse_start();
    n_checks++;
    if (AbortErr !== 1'b0 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL err_restart: got abort=%b busy=%b required 0/1", AbortErr, Busy);
    end
    wait_idle(cyc, to);
    n_checks++;
    if (to || Finished !== 1'b1 || sb.size() != 16) begin
      n_fail++;
      $display("FAIL err_rerun: got timeout=%0d fin=%b results=%0d required 0/1/16", to, Finished, sb.size());
    end
    sb.delete();
    $display("error: abort at idx 5 then clean rerun");
  endtask

  task automatic test_load_lockout();
    int cyc;
    bit to;
    exp_t e;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      ma[i] = $urandom_range(0, 200) - 100;
      mb[i] = $urandom_range(0, 200) - 100;
    end
    load_all();
    clr_cnt = 0;
    pulse_start();
    repeat (3) @(negedge Clock);
    LoadEn = 1'b1; LoadSel = 1'b0; LoadAddr = 4'd15; LoadData = 32'd777;
    @(negedge Clock);
    LoadSel = 1'b1; LoadData = 32'd888;
    @(negedge Clock);
    LoadEn = 1'b0;
    repeat (20) @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_idle(cyc, to);
    @(negedge Clock);
    n_checks++;
    if (to || clr_cnt != 16 || Finished !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_run: got timeout=%0d clears=%0d fin=%b required 0/16/1", to, clr_cnt, Finished);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ReadAddr = e.addr[3:0];
      #1;
      n_checks++;
      if (ReadData !== e.val) begin
        n_fail++;
        $display("FAIL lock_c[%0d]: got %0d required %0d", e.addr, $signed(ReadData), $signed(e.val));
      end
    end
    $display("lockout: loads and Start during Busy, %0d clears", clr_cnt);
  endtask

  task automatic test_reset_midrun();
    bit hit;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      ma[i] = i + 2;
      mb[i] = 7;
    end
    load_all();
    m_delay = 4;
    pulse_start();
    hit = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge Clock);
      #1;
      if (m_idx == 7 && Operation == EXP_MUL && m_cnt == 2) begin
        hit = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL midrun_reach: got idx=%0d required WAIT of idx 7", m_idx);
    end
    ResetN = 1'b0;
    #1;
    n_checks++;
    if (Operation !== EXP_IDLE || Busy !== 1'b0 || ClearAll !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_async: got op=%b busy=%b clr=%b required 000/0/0", Operation, Busy, ClearAll);
    end
    for (int i = 0; i < 16; i++) begin
      ReadAddr = i[3:0];
      #1;
      n_checks++;
      if (ReadData !== 32'd0) begin
        n_fail++;
        $display("FAIL midrun_c[%0d]: got %0d required 0", i, $signed(ReadData));
      end
    end
    @(negedge Clock);
    ResetN = 1'b1;
    sb.delete();
    m_delay = 2;
    $display("reset mid-run: outputs and C cleared");
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    m_never = 1'b1;
    pulse_start();
    @(negedge Clock);
`ifdef MATRIX_SEQ_TIMEOUT_EN
    n = 0;
    while (!AbortErr && n < 500) begin
      @(negedge Clock);
      n++;
    end
    n_checks++;
    if (n != EXP_TO || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_abort: got %0d cycles busy=%b required %0d/0", n, Busy, EXP_TO);
    end
`else
    n = 200;
    repeat (n) @(negedge Clock);
    n_checks++;
    if (Busy !== 1'b1 || AbortErr !== 1'b0 || Operation !== EXP_MUL) begin
      n_fail++;
      $display("FAIL timeout_hold: got busy=%b abort=%b op=%b required 1/0/101", Busy, AbortErr, Operation);
    end
`endif
    apply_reset();
    $display("timeout: Done withheld for %0d cycles", n);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_signed_and_same_cycle_load();
    test_error();
    test_load_lockout();
    test_reset_midrun();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_mult_sequencer.md
Name: matrix_mult_sequencer

Overview:
Initiator side of the Matrix_Multiplicator operand/handshake interface. Holds two 4x4 signed 32-bit matrices, A and B, loaded over a simple write port. It walks all 16 (row,col) pairs, and for each pair it drives row i of A onto ColumnA1..4 and column j of B onto RowB1..4, issues the multiply operation and waits for Done. Each Result is stored into the C matrix, which a host reads back.

Parameters:
MUL_OP, 3'b101, Operation code that requests a dot-product multiply.
IDLE_OP, 3'b000, Operation code driven when no multiply is requested.
TIMEOUT, 64, maximum WAIT cycles before abort (used only with the optional feature).

Ports:
Clock  in  1  system clock, rising edge.
ResetN  in  1  asynchronous, active-low reset.
LoadEn  in  1  write strobe for the A/B store.
LoadSel  in  1  0 selects A, 1 selects B.
LoadAddr  in  4  element index {row[1:0],col[1:0]}.
LoadData  in  32  signed element.
Start  in  1  begin a full 4x4 multiply.
ReadAddr  in  4  C element index {row,col}.
ReadData  out  32  C[ReadAddr], combinational read.
Busy  out  1  sequence in progress.
Finished  out  1  sticky: last sequence completed.
AbortErr  out  1  sticky: last sequence aborted.
Operation  out  3  to unit.
ClearAll  out  1  to unit; one-cycle clear pulse.
ColumnA1..ColumnA4  out  32 each  A[i][0..3].
RowB1..RowB4  out  32 each  B[0..3][j].
Error  in  1  from unit.
Done  in  1  from unit.
Result  in  32  signed dot product from unit.

Behaviour:
- Reset (ResetN=0, asynchronous):
  - State IDLE; idx=0.
  - A, B and C are all zero.
  - Busy=0, Finished=0, AbortErr=0, ClearAll=0, Operation=IDLE_OP.
  - ColumnA*=0, RowB*=0.
- Reset mid-sequence discards all progress. No partial C is preserved.
- Load port:
  - LoadEn=1 with Busy=0 writes the element at the next edge.
  - LoadEn is ignored while Busy=1.
- States and transitions:
  - IDLE: Start=1 takes it to ISSUE next cycle. At that edge: idx=0, Busy=1, Finished=0, AbortErr=0.
  - ISSUE:
    - Operands come from idx (i=idx[3:2], j=idx[1:0]). They are registered and held stable until CLEAR.
    - Operation=MUL_OP. Go to WAIT.
  - WAIT:
    - Hold Operation=MUL_OP and the operands.
    - Done=1 and Error=0: C[idx]<=Result, go to CLEAR.
    - Done=1 and Error=1: go to ABORT; C[idx] is unchanged.
    - Done=0: stay in WAIT.
  - CLEAR:
    - Operation=IDLE_OP and ClearAll=1 for exactly one cycle.
    - If idx==15 go to FINISH; otherwise idx++ and go to ISSUE.
  - FINISH: Busy=0, Finished=1, go to IDLE.
  - ABORT: Operation=IDLE_OP, ClearAll=1 for one cycle, Busy=0, AbortErr=1, go to IDLE.
- Simultaneous events:
  - Start while Busy=1 is ignored.
  - Start in the same cycle as LoadEn (both in IDLE): the write lands first, and the sequence uses the new value.
- Timing:
  - Minimum per-element latency is 3 cycles (ISSUE, WAIT with Done, CLEAR).
  - A full run takes at least 16*3+1 cycles after Start.
- Arithmetic: C stores Result verbatim. No widening or saturation is performed in this block.
- ReadData is valid at any time, including while Busy.

Optional Feature:
MATRIX_SEQ_TIMEOUT_EN
- Defined:
  - A WAIT-cycle counter is cleared on entry to WAIT.
  - When the counter reaches TIMEOUT with Done still 0, the FSM goes to ABORT and sets AbortErr=1.
- Undefined: there is no counter, and WAIT waits on Done indefinitely.

Decomposition:
- Shared package matrix_pkg holds:
  - op-code constants MUL_OP and IDLE_OP;
  - FSM state encoding (IDLE, ISSUE, WAIT, CLEAR, FINISH, ABORT);
  - 32-bit element typedef;
  - 4-bit index typedef.
- One sub-module, matrix_store_4x4: a 16x32 register file with a synchronous write and a combinational 4-lane row/column read. It is instantiated for A, B and C.

Test Plan:
1. Identity: load A=I, B[r][c]=r*4+c. Pulse Start with a model unit that returns the dot product with Done after 2 cycles. Required: C==B, Finished=1, AbortErr=0, 16 ClearAll pulses.
2. Signed values: A all 4, B all -5 -> every C element = -80.
3. Error path:
   - Stimulus: the model asserts Error with Done on idx=5.
   - Required: AbortErr=1, Busy=0, C[0..4] written, C[5..15] remain 0.
   - Then a second Start clears AbortErr.
4. Load lockout: LoadEn pulses with Busy=1 change nothing, and Start pulses while Busy do not restart idx.
5. Reset mid-run: drive ResetN=0 during WAIT of idx=7. Required: immediate Operation=000, Busy=0, C all 0.
6. Timeout (with MATRIX_SEQ_TIMEOUT_EN defined): Done is never asserted. Required: AbortErr=1 exactly TIMEOUT cycles after entering WAIT. Undefined build: Busy stays 1.
